// File: rtl/pong_pkg.sv
// Shared constants, state encoding and helpers for the pong engine.
// Default geometry lives here; the engine re-derives its working constants
// from its own parameters so that non-default builds stay consistent.
package pong_pkg;

    localparam int DEF_SCREEN_W   = 640;
    localparam int DEF_SCREEN_H   = 480;
    localparam int DEF_PAD_W      = 64;
    localparam int DEF_PAD_H      = 8;
    localparam int DEF_BALL_SZ    = 8;
    localparam int DEF_BALL_STEP  = 2;
    localparam int DEF_PAD_STEP   = 4;
    localparam int DEF_HOLD_FRAMES = 60;
    localparam int DEF_WIN_SCORE  = 9;

    // Direction encodings: dx 1 = right, dy 1 = down (screen y grows downward).
    localparam logic DIR_RIGHT = 1'b1;
    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_DOWN  = 1'b1;
    localparam logic DIR_UP    = 1'b0;

    typedef enum logic [1:0] {
        ST_SERVE    = 2'd0,
        ST_PLAY     = 2'd1,
        ST_SCORED   = 2'd2,
        ST_GAMEOVER = 2'd3
    } state_t;

    // Top-left coordinate that centres an object of length size in span.
    function automatic int centre_of(input int span, input int size);
        return (span - size) / 2;
    endfunction

    // One paddle step: left-only / right-only move with saturation, else hold.
    function automatic logic [9:0] pad_move(input logic [9:0] pos,
                                            input logic       go_left,
                                            input logic       go_right,
                                            input logic [9:0] step,
                                            input logic [9:0] max_pos);
        logic [10:0] sum;
        sum      = {1'b0, pos} + {1'b0, step};
        pad_move = pos;
        if (go_left && !go_right) begin
            pad_move = (pos < step) ? 10'd0 : pos - step;
        end else if (go_right && !go_left) begin
            pad_move = (sum > {1'b0, max_pos}) ? max_pos : sum[9:0];
        end
    endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer followed by a falling-edge detector.
// The flops reset to IDLE so that a line sitting at its idle level never
// produces a pulse when reset is released.
module sync_edge #(
    parameter logic IDLE = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_async,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    // Synchronize the input and keep one cycle of history for edge detection.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_meta <= IDLE;
            r_sync <= IDLE;
            r_prev <= IDLE;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_fall = r_prev & ~r_sync;

endmodule

// File: rtl/pong_engine.sv
// Pong game engine: paddles, ball physics, scoring and serve/hold sequencing.
// All positional state advances once per frame, on the falling edge of the
// synchronized v_synch.
// Build option: define PONG_SCORE_EN to enable score keeping, the post-miss
// hold (SCORED) and GAMEOVER. Without it a miss returns straight to SERVE and
// the score outputs read zero; point still pulses.
module pong_engine
    import pong_pkg::*;
#(
    parameter int SCREEN_W    = DEF_SCREEN_W,
    parameter int SCREEN_H    = DEF_SCREEN_H,
    parameter int PAD_W       = DEF_PAD_W,
    parameter int PAD_H       = DEF_PAD_H,
    parameter int BALL_SZ     = DEF_BALL_SZ,
    parameter int BALL_STEP   = DEF_BALL_STEP,
    parameter int PAD_STEP    = DEF_PAD_STEP,
    parameter int HOLD_FRAMES = DEF_HOLD_FRAMES,
    parameter int WIN_SCORE   = DEF_WIN_SCORE
) (
    input  logic       pixel_clock,
    input  logic       reset,
    input  logic       v_synch,
    input  logic       up_l,
    input  logic       up_r,
    input  logic       dn_l,
    input  logic       dn_r,
    input  logic       serve,
    output logic [9:0] ballx,
    output logic [8:0] bally,
    output logic [9:0] padup,
    output logic [9:0] padwn,
    output logic [3:0] score_up,
    output logic [3:0] score_dn,
    output logic       point
);

`ifdef PONG_SCORE_EN
    localparam bit SCORE_EN = 1'b1;
`else
    localparam bit SCORE_EN = 1'b0;
`endif

    localparam logic [9:0]  X_MAX     = 10'(SCREEN_W - BALL_SZ);
    localparam logic [9:0]  PAD_MAX   = 10'(SCREEN_W - PAD_W);
    localparam logic [8:0]  Y_TOP     = 9'(PAD_H);
    localparam logic [8:0]  Y_BOT     = 9'(SCREEN_H - PAD_H - BALL_SZ);
    localparam logic [9:0]  X_CTR     = 10'(centre_of(SCREEN_W, BALL_SZ));
    localparam logic [8:0]  Y_CTR     = 9'(centre_of(SCREEN_H, BALL_SZ));
    localparam logic [9:0]  PAD_CTR   = 10'(centre_of(SCREEN_W, PAD_W));
    localparam logic [9:0]  BSTEP_X   = 10'(BALL_STEP);
    localparam logic [8:0]  BSTEP_Y   = 9'(BALL_STEP);
    localparam logic [9:0]  PSTEP     = 10'(PAD_STEP);
    localparam logic [10:0] BALL_SZ_W = 11'(BALL_SZ);
    localparam logic [10:0] PAD_W_W   = 11'(PAD_W);
    localparam logic [3:0]  WIN       = 4'(WIN_SCORE);
    localparam logic [15:0] HOLD_LAST = 16'(HOLD_FRAMES - 1);
    localparam int          NUM_BTN   = 5;

    // ---------------------------------------------------------------
    // Input synchronization
    // ---------------------------------------------------------------
    logic                 w_tick;
    logic [NUM_BTN-1:0]   w_btn_raw;
    logic [NUM_BTN-1:0]   w_btn_sync;
    logic                 w_up_l, w_up_r, w_dn_l, w_dn_r, w_serve;

    sync_edge #(.IDLE(1'b1)) u_vsync (
        .i_clk   (pixel_clock),
        .i_rst   (reset),
        .i_async (v_synch),
        .o_fall  (w_tick)
    );

    assign w_btn_raw = {serve, dn_r, dn_l, up_r, up_l};

    for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn_sync
        logic r_meta;
        logic r_sync;
        // Two-flop synchronizer for one button; buttons idle low.
        always_ff @(posedge pixel_clock or posedge reset) begin
            if (reset) begin
                r_meta <= 1'b0;
                r_sync <= 1'b0;
            end else begin
                r_meta <= w_btn_raw[gi];
                r_sync <= r_meta;
            end
        end
        assign w_btn_sync[gi] = r_sync;
    end

    assign w_up_l  = w_btn_sync[0];
    assign w_up_r  = w_btn_sync[1];
    assign w_dn_l  = w_btn_sync[2];
    assign w_dn_r  = w_btn_sync[3];
    assign w_serve = w_btn_sync[4];

    // ---------------------------------------------------------------
    // Game state
    // ---------------------------------------------------------------
    state_t      r_state, w_state_next;
    logic [9:0]  r_ballx, w_ballx_next;
    logic [8:0]  r_bally, w_bally_next;
    logic [9:0]  r_padup, w_padup_next;
    logic [9:0]  r_padwn, w_padwn_next;
    logic [3:0]  r_score_up, w_score_up_next;
    logic [3:0]  r_score_dn, w_score_dn_next;
    logic        r_dx, w_dx_next;
    logic        r_dy, w_dy_next;
    logic        r_serve_dx, w_serve_dx_next;
    logic [15:0] r_hold, w_hold_next;
    logic        r_point, w_point_next;

    // Candidate ball motion for a PLAY tick, including wall/paddle reflection.
    logic [9:0]  w_mv_x;
    logic [8:0]  w_mv_y;
    logic        w_mv_dx, w_mv_dy;
    logic        w_miss, w_miss_top;
    logic        w_hit_up, w_hit_dn;

    // Paddle overlap uses the ball and paddle positions as they stand before the tick.
    assign w_hit_up = (({1'b0, r_ballx} + BALL_SZ_W) > {1'b0, r_padup}) &&
                      ({1'b0, r_ballx} < ({1'b0, r_padup} + PAD_W_W));
    assign w_hit_dn = (({1'b0, r_ballx} + BALL_SZ_W) > {1'b0, r_padwn}) &&
                      ({1'b0, r_ballx} < ({1'b0, r_padwn} + PAD_W_W));

    // Ball motion: x and y are resolved independently so a corner hit reflects both.
    always_comb begin
        w_mv_x     = r_ballx;
        w_mv_dx    = r_dx;
        w_mv_y     = r_bally;
        w_mv_dy    = r_dy;
        w_miss     = 1'b0;
        w_miss_top = 1'b0;

        if (r_dx == DIR_RIGHT) begin
            if ((r_ballx + BSTEP_X) >= X_MAX) begin
                w_mv_x  = X_MAX;
                w_mv_dx = DIR_LEFT;
            end else begin
                w_mv_x = r_ballx + BSTEP_X;
            end
        end else begin
            if (r_ballx <= BSTEP_X) begin
                w_mv_x  = 10'd0;
                w_mv_dx = DIR_RIGHT;
            end else begin
                w_mv_x = r_ballx - BSTEP_X;
            end
        end

        if (r_dy == DIR_UP) begin
            if (r_bally <= (Y_TOP + BSTEP_Y)) begin
                if (w_hit_up) begin
                    w_mv_y  = Y_TOP;
                    w_mv_dy = DIR_DOWN;
                end else begin
                    w_miss     = 1'b1;
                    w_miss_top = 1'b1;
                end
            end else begin
                w_mv_y = r_bally - BSTEP_Y;
            end
        end else begin
            if ((r_bally + BSTEP_Y) >= Y_BOT) begin
                if (w_hit_dn) begin
                    w_mv_y  = Y_BOT;
                    w_mv_dy = DIR_UP;
                end else begin
                    w_miss = 1'b1;
                end
            end else begin
                w_mv_y = r_bally + BSTEP_Y;
            end
        end
    end

    // Next-state and next-value logic, applied only on a frame tick.
    always_comb begin
        w_state_next    = r_state;
        w_ballx_next    = r_ballx;
        w_bally_next    = r_bally;
        w_padup_next    = r_padup;
        w_padwn_next    = r_padwn;
        w_score_up_next = r_score_up;
        w_score_dn_next = r_score_dn;
        w_dx_next       = r_dx;
        w_dy_next       = r_dy;
        w_serve_dx_next = r_serve_dx;
        w_hold_next     = r_hold;
        w_point_next    = 1'b0;

        if (r_state != ST_GAMEOVER) begin
            w_padup_next = pad_move(r_padup, w_up_l, w_up_r, PSTEP, PAD_MAX);
            w_padwn_next = pad_move(r_padwn, w_dn_l, w_dn_r, PSTEP, PAD_MAX);
        end

        case (r_state)
            ST_SERVE: begin
                if (w_serve) begin
                    w_state_next = ST_PLAY;
                end
            end
            ST_PLAY: begin
                if (w_miss) begin
                    // Ball stays where it was; next serve heads toward the loser
                    // and alternates its horizontal direction.
                    w_point_next    = 1'b1;
                    w_dy_next       = w_miss_top ? DIR_UP : DIR_DOWN;
                    w_dx_next       = ~r_serve_dx;
                    w_serve_dx_next = ~r_serve_dx;
                    if (SCORE_EN) begin
                        if (w_miss_top) begin
                            w_score_dn_next = (r_score_dn >= WIN) ? WIN : r_score_dn + 4'd1;
                        end else begin
                            w_score_up_next = (r_score_up >= WIN) ? WIN : r_score_up + 4'd1;
                        end
                        if ((w_score_up_next == WIN) || (w_score_dn_next == WIN)) begin
                            w_state_next = ST_GAMEOVER;
                        end else begin
                            w_state_next = ST_SCORED;
                            w_hold_next  = 16'd0;
                        end
                    end else begin
                        w_state_next = ST_SERVE;
                        w_ballx_next = X_CTR;
                        w_bally_next = Y_CTR;
                    end
                end else begin
                    w_ballx_next = w_mv_x;
                    w_bally_next = w_mv_y;
                    w_dx_next    = w_mv_dx;
                    w_dy_next    = w_mv_dy;
                end
            end
            ST_SCORED: begin
                if (r_hold == HOLD_LAST) begin
                    w_hold_next  = 16'd0;
                    w_state_next = ST_SERVE;
                    w_ballx_next = X_CTR;
                    w_bally_next = Y_CTR;
                end else begin
                    w_hold_next = r_hold + 16'd1;
                end
            end
            ST_GAMEOVER: begin
                if (w_serve) begin
                    w_score_up_next = 4'd0;
                    w_score_dn_next = 4'd0;
                    w_state_next    = ST_SERVE;
                    w_ballx_next    = X_CTR;
                    w_bally_next    = Y_CTR;
                end
            end
            default: begin
                w_state_next = ST_SERVE;
            end
        endcase
    end

    // State register: everything positional moves only on the frame tick.
    always_ff @(posedge pixel_clock or posedge reset) begin
        if (reset) begin
            r_state    <= ST_SERVE;
            r_ballx    <= X_CTR;
            r_bally    <= Y_CTR;
            r_padup    <= PAD_CTR;
            r_padwn    <= PAD_CTR;
            r_score_up <= 4'd0;
            r_score_dn <= 4'd0;
            r_dx       <= DIR_RIGHT;
            r_dy       <= DIR_DOWN;
            r_serve_dx <= DIR_RIGHT;
            r_hold     <= 16'd0;
            r_point    <= 1'b0;
        end else begin
            r_point <= w_tick & w_point_next;
            if (w_tick) begin
                r_state    <= w_state_next;
                r_ballx    <= w_ballx_next;
                r_bally    <= w_bally_next;
                r_padup    <= w_padup_next;
                r_padwn    <= w_padwn_next;
                r_score_up <= w_score_up_next;
                r_score_dn <= w_score_dn_next;
                r_dx       <= w_dx_next;
                r_dy       <= w_dy_next;
                r_serve_dx <= w_serve_dx_next;
                r_hold     <= w_hold_next;
            end
        end
    end

    assign ballx    = r_ballx;
    assign bally    = r_bally;
    assign padup    = r_padup;
    assign padwn    = r_padwn;
    assign score_up = SCORE_EN ? r_score_up : 4'd0;
    assign score_dn = SCORE_EN ? r_score_dn : 4'd0;
    assign point    = r_point;

endmodule
